// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for elastic pipeline-stage registers: FSM state encoding,
// occupancy width and the packed payload layouts of the stage boundaries.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } pipe_state_e;

    localparam int OCC_W = 2;

    // ID/EX boundary: 160 bits, the default stage width.
    typedef struct packed {
        logic [31:0] pc;
        logic [29:0] control;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic        predict;
        logic        invalid;
    } id_ex_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] control;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        invalid;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with valid/ready handshake and 2-entry skid
// buffer. Optional PIPE_STAGE_ZERO_ON_FLUSH_EN clears payload on flush/drain.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 160,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [OCC_W-1:0]  occupancy
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_data_q;

    // Handshake outputs decode straight from the state register, so ready never
    // depends combinationally on out_ready.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        occupancy = '0;
        case (state_q)
            PS_FULL: begin
                out_valid = 1'b1;
                occupancy = OCC_W'(1);
            end
            PS_SKID: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
                occupancy = OCC_W'(2);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        case (state_q)
            PS_EMPTY: begin
                if (in_fire) begin
                    state_d     = PS_FULL;
                    main_data_d = in_data;
                end
            end
            PS_FULL: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                end else if (in_fire) begin
                    state_d     = PS_SKID;
                    skid_data_d = in_data;
                end else if (out_fire) begin
                    state_d = PS_EMPTY;
`ifdef PIPE_STAGE_ZERO_ON_FLUSH_EN
                    main_data_d = RST_VAL;
`endif
                end
            end
            PS_SKID: begin
                if (out_fire) begin
                    state_d     = PS_FULL;
                    main_data_d = skid_data_q;
                end
            end
            default: state_d = PS_EMPTY;
        endcase

        // A beat leaving this cycle still completes; everything else is dropped.
        if (flush) begin
            state_d = PS_EMPTY;
`ifdef PIPE_STAGE_ZERO_ON_FLUSH_EN
            main_data_d = RST_VAL;
            skid_data_d = RST_VAL;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PS_EMPTY;
            main_data_q <= RST_VAL;
            skid_data_q <= RST_VAL;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised and directed bench for pipe_stage_buf against a queue-based model
// of the stage contents (arrival order, capacity two, flush empties).
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int                DW = $bits(id_ex_payload_t);
    localparam logic [DW-1:0]     RV = DW'(160'h0000_1111_2222_3333_DEAD_BEEF);

    logic              clk, clk_en, rst;
    logic              in_valid, in_ready, out_valid, out_ready, flush;
    logic [DW-1:0]     in_data, out_data;
    logic [OCC_W-1:0]  occupancy;

    logic [DW-1:0]     mq[$];
    int                n_tests, n_fail;

    pipe_stage_buf #(.DATA_W(DW), .RST_VAL(RV)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .occupancy(occupancy)
    );

    always #5 clk = clk_en ? ~clk : clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DW; k += 32) r = (r << 32) | DW'($urandom);
        return r;
    endfunction

    // Compare DUT against the model: valid iff beats held, ready iff room left.
    task automatic compare();
        chk("out_valid", DW'(out_valid), DW'(mq.size() != 0));
        chk("in_ready", DW'(in_ready), DW'(mq.size() < 2));
        chk("occupancy", DW'(occupancy), DW'(mq.size()));
        if (mq.size() != 0) chk("out_data", out_data, mq[0]);
`ifdef PIPE_STAGE_ZERO_ON_FLUSH_EN
        else chk("out_data_bubble", out_data, RV);
`endif
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
        bit m_ready, m_valid;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        m_ready = mq.size() < 2;
        m_valid = mq.size() != 0;
        if (m_valid && ordy) void'(mq.pop_front());
        if (v && m_ready) mq.push_back(d);
        if (fl) mq.delete();
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          v;
        n_tests = 0; n_fail = 0;
        clk = 0; clk_en = 0; rst = 0;
        in_valid = 0; in_data = '0; out_ready = 0; flush = 0;

        // Reset with clock stopped
        #2 rst = 1;
        #1;
        mq.delete();
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        chk("rst_occupancy", DW'(occupancy), DW'(0));
        chk("rst_out_data", out_data, RV);
        clk_en = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        compare();

        // Streaming 1..10
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, DW'(i), 1'b1, 1'b0);
            chk("stream_data", out_data, DW'(i));
            chk("stream_occ", DW'(occupancy), DW'(1));
        end
        step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure 0xA, 0xB, 0xC
        step(1'b1, DW'('hA), 1'b0, 1'b0);
        step(1'b1, DW'('hB), 1'b0, 1'b0);
        chk("bp_in_ready", DW'(in_ready), DW'(0));
        chk("bp_occ", DW'(occupancy), DW'(2));
        chk("bp_main", out_data, DW'('hA));
        step(1'b1, DW'('hC), 1'b0, 1'b0);
        chk("bp_hold_main", out_data, DW'('hA));
        step(1'b1, DW'('hC), 1'b1, 1'b0);
        chk("bp_second", out_data, DW'('hB));
        step(1'b1, DW'('hC), 1'b1, 1'b0);
        chk("bp_third", out_data, DW'('hC));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("bp_drained", DW'(out_valid), DW'(0));

        // Flush in SKID with simultaneous out_fire
        step(1'b1, DW'('hA), 1'b0, 1'b0);
        step(1'b1, DW'('hB), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("flush_occ", DW'(occupancy), DW'(0));
        chk("flush_valid", DW'(out_valid), DW'(0));
        chk("flush_ready", DW'(in_ready), DW'(1));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("flush_no_b", DW'(out_valid), DW'(0));

        // Flush while EMPTY with a beat accepted
        step(1'b1, DW'('h55), 1'b1, 1'b1);
        chk("flush_in_valid", DW'(out_valid), DW'(0));
`ifdef PIPE_STAGE_ZERO_ON_FLUSH_EN
        chk("flush_in_data", out_data, RV);
`endif

        // Randomised traffic; upstream holds data while stalled
        v = 1'b0; d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(v && mq.size() == 2)) begin
                v = 1'($urandom_range(0, 3) != 0);
                d = rnd_data();
            end
            step(v, d, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Async reset mid-SKID
        step(1'b1, DW'('hA), 1'b0, 1'b0);
        step(1'b1, DW'('hB), 1'b0, 1'b0);
        in_valid = 0;
        #2 rst = 1;
        #1;
        mq.delete();
        chk("arst_out_valid", DW'(out_valid), DW'(0));
        chk("arst_in_ready", DW'(in_ready), DW'(1));
        chk("arst_occ", DW'(occupancy), DW'(0));
        chk("arst_out_data", out_data, RV);
        @(negedge clk);
        rst = 0;
        step(1'b1, DW'('h77), 1'b1, 1'b0);
        chk("post_rst_valid", DW'(out_valid), DW'(1));
        chk("post_rst_data", out_data, DW'('h77));
        step(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
